omsp_spm_key_reader: RTL and testbench
======================================

# omsp_spm_key_reader

Reads a protected module's key out of the SPM array and streams it as 16-bit words over a valid/ready handshake. It is the read-side counterpart of the word-wise key write path (`key_in`/`key_idx`), and it sits between the SPM control block and a word-serial consumer such as the MAC engine. It drives `spm_key_select` and checks `spm_key_select_valid`. It then latches the combinational `key_out` into a shadow register and streams it out. The shadow register is zeroized when streaming finishes.

## Interface
Parameters:
- `KEY_IDX_SIZE`, default 2: width of the word index; the key has 2**KEY_IDX_SIZE words.
- `SECURITY`, default 64: key width in bits; it must equal 16 * 2**KEY_IDX_SIZE.

Ports:
- `mclk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `key_select`  in  16  address inside the target SM; registered on accepted `start`.
- `abort`  in  1  synchronous cancel; effective in any non-IDLE state.
- `spm_key_select`  out  16  registered select to SPM control.
- `spm_key_select_valid`  in  1  from SPM control: select hits an enabled SM.
- `key_out`  in  SECURITY  key from SPM control, bit-ordered [0:SECURITY-1].
- `word_data`  out  16  current key word.
- `word_idx`  out  KEY_IDX_SIZE  index of `word_data`.
- `word_last`  out  1  high with the final word.
- `word_valid`  out  1  word available.
- `word_ready`  in  1  consumer accepts the word.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse: full key transferred.
- `error`  out  1  one-cycle pulse: select invalid.

## Operation
- FSM states: IDLE, SELECT, STREAM, CLEAR.
- IDLE: if `start`=1, register `spm_key_select`<=`key_select` and go to SELECT.
- SELECT (exactly 1 cycle):
  - If `abort`=1, go to CLEAR.
  - Else if `spm_key_select_valid`=1, set shadow<=`key_out` and word counter<=0, then go to STREAM.
  - Else pulse `error`, set `spm_key_select`<=0, and go to IDLE.
- STREAM:
  - `word_valid`=1.
  - `word_data`=shadow[16*idx +: 16], so word 0 is `key_out`[0:15].
  - `word_idx`=counter.
  - `word_last`=(counter==2**KEY_IDX_SIZE-1).
  - A transfer occurs when `word_valid`&`word_ready` in the same cycle.
  - On a transfer that is not last, counter+1.
  - On the last transfer, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - shadow<=0, `spm_key_select`<=0, counter<=0.
  - `done`=1 only if entered via the last transfer; an abort exit gives `done`=0.
  - Then go to IDLE.
- `abort` in STREAM goes to CLEAR, even if a transfer happens in the same cycle. That transfer still counts as taken by the consumer, but `done` stays 0.
- `start` while `busy`=1 is ignored. `start` and `abort` together in IDLE: `start` wins (abort has no effect in IDLE).
- Counter arithmetic is KEY_IDX_SIZE bits. It never wraps, because the last word exits STREAM.
- The SPM changing or being destroyed after SELECT does not affect the streamed words; the shadow copy is used.

## Timing
- Reset values: state IDLE, shadow 0, counter 0, `spm_key_select`=0. All outputs are 0: `word_data`, `word_idx`, `word_last`, `word_valid`, `busy`, `done`, `error`.
- Reset asserted mid-stream drops `word_valid` immediately (asynchronously) and zeroizes the shadow.
- `start` accepted at edge T: SELECT in cycle T+1. The first `word_valid` is in cycle T+2.
- With `word_ready` held at 1, word k transfers in cycle T+2+k. With N=2**KEY_IDX_SIZE words, `done` is in cycle T+2+N and IDLE is reached at T+3+N. The next `start` can be accepted at edge T+3+N.
- Invalid select: `error` is high in cycle T+2 and `busy` drops the same cycle.
- While `word_valid`=1 and `word_ready`=0, `word_data`, `word_idx` and `word_last` stay stable.
- All outputs are registered or decoded from state, shadow and counter only. There is no combinational path from `word_ready` or `key_out` to any output.

## Test plan
- Nominal (KEY_IDX_SIZE=2): `key_out`=64'h0123_4567_89AB_CDEF, valid=1, `start` at T, ready=1.
  - Words 0123, 4567, 89AB, CDEF appear in cycles T+2..T+5, with `word_last` only on CDEF.
  - `done` is in T+6. `spm_key_select` returns to 0 and the shadow reads 0.
- Invalid select: `spm_key_select_valid`=0 in SELECT -> `error` pulse in T+2, no `word_valid`, `done`=0, `spm_key_select`=0.
- Backpressure: `word_ready` toggles 0,0,1,0,1,1,0,1.
  - Each word is held stable while ready=0.
  - Exactly 4 transfers happen in order, and `done` follows the fourth transfer by one cycle.
- Abort after word 1 is transferred -> `word_valid`=0 the next cycle, CLEAR, no `done`, shadow zeroized, `busy`=0 two cycles after the abort.
- Key change mid-stream: change `key_out` to all-ones after SELECT -> the streamed words still equal the originally latched key. A `start` pulse while `busy`=1 has no effect.
- Async reset: assert `reset_n`=0 mid-stream between clock edges -> all outputs go to 0 immediately. After release, `start` is accepted normally.

Source files
------------

// File: rtl/omsp_spm_key_reader.sv
// ----------------------------------------------------------------------------
// omsp_spm_key_reader : snapshots an SM key from SPM control, streams 16-bit words
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module omsp_spm_key_reader #(
  parameter int KEY_IDX_SIZE = 2,
  parameter int SECURITY     = 64
) (
  input  logic                    mclk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [15:0]             key_select,
  input  logic                    abort,
  output logic [15:0]             spm_key_select,
  input  logic                    spm_key_select_valid,
  input  logic [SECURITY-1:0]     key_out,
  output logic [15:0]             word_data,
  output logic [KEY_IDX_SIZE-1:0] word_idx,
  output logic                    word_last,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int NWORDS = 2 ** KEY_IDX_SIZE;
  localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_STREAM = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             sel_q, sel_d;
  logic [SECURITY-1:0]     shadow_q, shadow_d;
  logic [KEY_IDX_SIZE-1:0] cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    in_stream;
  logic                    is_last;
  logic [15:0]             cur_word;

  assign in_stream = (state_q == ST_STREAM);
  assign is_last   = (cnt_q == LAST_IDX);

  // Key bit 0 (SPM ordering) sits at the MSB of the packed vector, so word k
  // is taken counting down from the top.
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (cnt_q == KEY_IDX_SIZE'(i)) begin
        cur_word = shadow_q[SECURITY-1-16*i -: 16];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = key_select;
          state_d = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (abort) begin
          state_d = ST_CLEAR;
        end else if (spm_key_select_valid) begin
          shadow_d = key_out;
          cnt_d    = '0;
          state_d  = ST_STREAM;
        end else begin
          error_d = 1'b1;
          sel_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_STREAM: begin
        if (abort) begin
          state_d = ST_CLEAR;
        end else if (word_ready) begin
          if (is_last) begin
            done_d  = 1'b1;
            state_d = ST_CLEAR;
          end else begin
            cnt_d = cnt_q + KEY_IDX_SIZE'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Secrets are wiped on the way into CLEAR so the key never lingers.
    if (state_d == ST_CLEAR || state_q == ST_CLEAR) begin
      shadow_d = '0;
      sel_d    = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign spm_key_select = sel_q;
  assign word_valid     = in_stream;
  assign word_data      = in_stream ? cur_word : 16'h0000;
  assign word_idx       = in_stream ? cnt_q : '0;
  assign word_last      = in_stream & is_last;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign error          = error_q;

endmodule

`default_nettype wire

// File: tb/tb_omsp_spm_key_reader.sv
// ----------------------------------------------------------------------------
// tb_omsp_spm_key_reader : directed self-checking bench for omsp_spm_key_reader
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_omsp_spm_key_reader;

  logic        mclk;
  logic        reset_n;
  logic        start;
  logic [15:0] key_select;
  logic        abort;
  logic [15:0] spm_key_select;
  logic        spm_key_select_valid;
  logic [63:0] key_out;
  logic [15:0] word_data;
  logic [1:0]  word_idx;
  logic        word_last;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_w [4];

  omsp_spm_key_reader #(
    .KEY_IDX_SIZE (2),
    .SECURITY     (64)
  ) dut (
    .mclk                 (mclk),
    .reset_n              (reset_n),
    .start                (start),
    .key_select           (key_select),
    .abort                (abort),
    .spm_key_select       (spm_key_select),
    .spm_key_select_valid (spm_key_select_valid),
    .key_out              (key_out),
    .word_data            (word_data),
    .word_idx             (word_idx),
    .word_last            (word_last),
    .word_valid           (word_valid),
    .word_ready           (word_ready),
    .busy                 (busy),
    .done                 (done),
    .error                (error)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  // Check the streaming outputs for word k of the expected table.
  task automatic check_word(input string tag, input int k);
    check_eq({tag, " valid"}, word_valid, 1'b1);
    check_eq({tag, " data"},  word_data,  exp_w[k]);
    check_eq({tag, " idx"},   word_idx,   k[1:0]);
    check_eq({tag, " last"},  word_last,  (k == 3));
  endtask

  initial begin
    logic [7:0] pat;
    int         k;
    int         seen;

    reset_n              = 1'b0;
    start                = 1'b0;
    key_select           = 16'h0000;
    abort                = 1'b0;
    spm_key_select_valid = 1'b0;
    key_out              = 64'h0;
    word_ready           = 1'b0;

    // ---------------- reset state ----------------
    step();
    step();
    check_eq("rst word_valid", word_valid, 1'b0);
    check_eq("rst word_data",  word_data,  16'h0);
    check_eq("rst word_idx",   word_idx,   2'd0);
    check_eq("rst word_last",  word_last,  1'b0);
    check_eq("rst busy",       busy,       1'b0);
    check_eq("rst done",       done,       1'b0);
    check_eq("rst error",      error,      1'b0);
    check_eq("rst sel",        spm_key_select, 16'h0);
    reset_n = 1'b1;
    step();

    // ---------------- nominal ----------------
    key_out              = 64'h0123_4567_89AB_CDEF;
    exp_w[0] = 16'h0123; exp_w[1] = 16'h4567; exp_w[2] = 16'h89AB; exp_w[3] = 16'hCDEF;
    spm_key_select_valid = 1'b1;
    word_ready           = 1'b1;
    key_select           = 16'h00A5;
    start                = 1'b1;
    step();                                   // edge T -> SELECT
    start = 1'b0;
    check_eq("nom sel busy",  busy,           1'b1);
    check_eq("nom sel reg",   spm_key_select, 16'h00A5);
    check_eq("nom sel valid", word_valid,     1'b0);
    step();                                   // cycle T+2
    for (int i = 0; i < 4; i++) begin
      check_word("nom word", i);
      step();
    end
    check_eq("nom done",      done,           1'b1);
    check_eq("nom clr valid", word_valid,     1'b0);
    check_eq("nom clr sel",   spm_key_select, 16'h0);
    check_eq("nom clr shadow", dut.shadow_q,  64'h0);
    check_eq("nom clr busy",  busy,           1'b1);
    step();
    check_eq("nom idle busy", busy, 1'b0);
    check_eq("nom idle done", done, 1'b0);

    // ---------------- invalid select ----------------
    spm_key_select_valid = 1'b0;
    key_select           = 16'h1234;
    start                = 1'b1;
    step();
    start = 1'b0;
    check_eq("inv sel reg", spm_key_select, 16'h1234);
    step();                                   // T+2
    check_eq("inv error", error,          1'b1);
    check_eq("inv busy",  busy,           1'b0);
    check_eq("inv valid", word_valid,     1'b0);
    check_eq("inv done",  done,           1'b0);
    check_eq("inv sel",   spm_key_select, 16'h0);
    step();
    check_eq("inv error pulse", error, 1'b0);

    // ---------------- backpressure ----------------
    key_out              = 64'hDEAD_BEEF_CAFE_F00D;
    exp_w[0] = 16'hDEAD; exp_w[1] = 16'hBEEF; exp_w[2] = 16'hCAFE; exp_w[3] = 16'hF00D;
    spm_key_select_valid = 1'b1;
    word_ready           = 1'b0;
    key_select           = 16'h0042;
    start                = 1'b1;
    step();
    start = 1'b0;
    step();                                   // T+2
    pat  = 8'b1011_0100;                      // ready sequence 0,0,1,0,1,1,0,1
    k    = 0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      word_ready = pat[c];
      check_word("bp word", k);
      if (word_valid && word_ready) begin
        seen++;
        k++;
      end
      step();
    end
    word_ready = 1'b1;
    check_eq("bp transfers", seen, 4);
    check_eq("bp done",      done, 1'b1);
    step();
    check_eq("bp idle", busy, 1'b0);

    // ---------------- abort after word 1 ----------------
    key_out = 64'h1111_2222_3333_4444;
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();                                   // T+2: word 0
    check_word("ab word", 0);
    step();                                   // T+3: word 1, abort same cycle
    check_word("ab word", 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("ab clr valid",  word_valid,   1'b0);
    check_eq("ab clr done",   done,         1'b0);
    check_eq("ab clr busy",   busy,         1'b1);
    check_eq("ab clr shadow", dut.shadow_q, 64'h0);
    check_eq("ab clr sel",    spm_key_select, 16'h0);
    step();
    check_eq("ab idle busy", busy, 1'b0);
    check_eq("ab idle done", done, 1'b0);

    // ---------------- key change mid-stream, start+abort in idle ----------------
    key_out    = 64'hA1A2_B1B2_C1C2_D1D2;
    exp_w[0] = 16'hA1A2; exp_w[1] = 16'hB1B2; exp_w[2] = 16'hC1C2; exp_w[3] = 16'hD1D2;
    key_select = 16'h0C0C;
    start      = 1'b1;
    abort      = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_eq("kc start wins busy", busy, 1'b1);
    step();                                   // shadow latched
    key_out    = 64'hFFFF_FFFF_FFFF_FFFF;
    key_select = 16'h7777;
    start      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_word("kc word", i);
      check_eq("kc sel hold", spm_key_select, 16'h0C0C);
      step();
      start = 1'b0;
    end
    check_eq("kc done", done, 1'b1);
    step();
    check_eq("kc idle busy", busy, 1'b0);

    // ---------------- async reset mid-stream ----------------
    key_out    = 64'h5A5A_6B6B_7C7C_8D8D;
    exp_w[0] = 16'h5A5A; exp_w[1] = 16'h6B6B; exp_w[2] = 16'h7C7C; exp_w[3] = 16'h8D8D;
    word_ready = 1'b0;
    key_select = 16'h0099;
    start      = 1'b1;
    step();
    start = 1'b0;
    step();
    check_word("ar pre", 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar valid",  word_valid,     1'b0);
    check_eq("ar data",   word_data,      16'h0);
    check_eq("ar last",   word_last,      1'b0);
    check_eq("ar busy",   busy,           1'b0);
    check_eq("ar sel",    spm_key_select, 16'h0);
    check_eq("ar shadow", dut.shadow_q,   64'h0);
    step();
    reset_n    = 1'b1;
    word_ready = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("ar restart busy", busy, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      check_word("ar word", i);
      step();
    end
    check_eq("ar done", done, 1'b1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
